// File: rtl/cgra_branch_pkg.sv
// Shared types and defaults for the configurable merge-set branch selector.
// Configuration entries carry a fixed-width destination so one type fits every N_OUT.
package cgra_branch_pkg;

    localparam int N_IN_DEF  = 16;
    localparam int N_OUT_DEF = 16;
    localparam int CNT_W_DEF = 16;

    // Widest destination field supported; N_OUT may not exceed 2**SEL_MAX_W.
    localparam int SEL_MAX_W = 8;

    typedef struct packed {
        logic                 en;
        logic [SEL_MAX_W-1:0] dest;
    } branch_cfg_t;

    function automatic logic [SEL_MAX_W-1:0] identity_dest(input int i, input int n_out);
        return SEL_MAX_W'(i % n_out);
    endfunction

    function automatic branch_cfg_t reset_entry(input int i, input int n_out);
        branch_cfg_t e;
        e.en   = 1'b1;
        e.dest = identity_dest(i, n_out);
        return e;
    endfunction

endpackage

// File: rtl/branch_route_col.sv
// One output column: OR-merge of the inputs routed here, plus "two or more sources"
// flags for both the live request vector and the static routing map.
module branch_route_col
    import cgra_branch_pkg::*;
#(
    parameter int N_IN = N_IN_DEF,
    parameter int COL  = 0
) (
    input  branch_cfg_t [N_IN-1:0] i_cfg,
    input  logic [N_IN-1:0]        i_req,
    output logic                   o_any,
    output logic                   o_multi,
    output logic                   o_static_multi
);

    logic [N_IN-1:0] w_route;
    logic [N_IN-1:0] w_src;

    // Out-of-range destinations never equal any COL, so such inputs simply drop.
    generate
        for (genvar i = 0; i < N_IN; i++) begin : g_route
            assign w_route[i] = i_cfg[i].en && (i_cfg[i].dest == SEL_MAX_W'(COL));
        end
    endgenerate

    assign w_src = w_route & i_req;
    assign o_any = |w_src;

    function automatic logic two_plus(input logic [N_IN-1:0] v);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (v[i] && seen) multi = 1'b1;
            if (v[i])         seen  = 1'b1;
        end
        return multi;
    endfunction

    assign o_multi        = two_plus(w_src);
    assign o_static_multi = two_plus(w_route);

endmodule

// File: rtl/branch_selector_cfg.sv
// Registered, double-buffered merge-set branch selector with per-input enable,
// static fan-in conflict flag and a saturating runtime collision counter.
module branch_selector_cfg
    import cgra_branch_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int N_OUT = N_OUT_DEF,
    parameter int SEL_W = $clog2(N_OUT),
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [N_IN-1:0]         merge_set_in,
    input  logic                    cfg_we,
    input  logic [$clog2(N_IN)-1:0] cfg_addr,
    input  logic [SEL_W:0]          cfg_data,
    input  logic                    cfg_commit,
    input  logic                    cnt_clr,
    output logic                    out_valid,
    output logic [N_OUT-1:0]        merge_set_out,
    output logic                    cfg_conflict,
    output logic [CNT_W-1:0]        collision_cnt
);

    localparam int AW = $clog2(N_IN);

    branch_cfg_t [N_IN-1:0] r_shadow;
    branch_cfg_t [N_IN-1:0] r_active;
    logic                   r_commit_pend;
    logic                   r_conflict;
    logic                   r_valid;
    logic [N_OUT-1:0]       r_out;
    logic [CNT_W-1:0]       r_cnt;

    logic [N_IN-1:0]        w_req;
    logic [N_OUT-1:0]       w_col_any;
    logic [N_OUT-1:0]       w_col_multi;
    logic [N_OUT-1:0]       w_col_static;
    logic                   w_addr_ok;
    branch_cfg_t            w_wr_entry;

    generate
        if (N_IN == (1 << AW)) begin : g_addr_full
            assign w_addr_ok = 1'b1;
        end else begin : g_addr_part
            assign w_addr_ok = int'(cfg_addr) < N_IN;
        end
    endgenerate

    assign w_wr_entry.en   = cfg_data[SEL_W];
    assign w_wr_entry.dest = SEL_MAX_W'(cfg_data[SEL_W-1:0]);

    // Gating with in_valid makes idle cycles register zero and never count collisions.
    assign w_req = merge_set_in & {N_IN{in_valid}};

    generate
        for (genvar o = 0; o < N_OUT; o++) begin : g_col
            branch_route_col #(
                .N_IN (N_IN),
                .COL  (o)
            ) u_col (
                .i_cfg          (r_active),
                .i_req          (w_req),
                .o_any          (w_col_any[o]),
                .o_multi        (w_col_multi[o]),
                .o_static_multi (w_col_static[o])
            );
        end
    endgenerate

    // NOTE: the config arrays are reset element by element because the identity map
    // is the architectural power-on routing, not a don't-care.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_IN; i++) begin
                r_shadow[i] <= reset_entry(i, N_OUT);
                r_active[i] <= reset_entry(i, N_OUT);
            end
            r_commit_pend <= 1'b0;
            r_conflict    <= 1'(N_IN > N_OUT);
        end else begin
            // NOTE: non-blocking here so a same-cycle write and commit see the pre-edge shadow.
            if (cfg_we && w_addr_ok) begin
                r_shadow[cfg_addr] <= w_wr_entry;
            end
            if (cfg_commit) begin
                r_active <= r_shadow;
            end
            r_commit_pend <= cfg_commit;
            if (r_commit_pend) begin
                r_conflict <= |w_col_static;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_out   <= '0;
        end else begin
            r_valid <= in_valid;
            r_out   <= w_col_any;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_cnt <= '0;
        end else if ((|w_col_multi) && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out_valid     = r_valid;
    assign merge_set_out = r_out;
    assign cfg_conflict  = r_conflict;
    assign collision_cnt = r_cnt;

endmodule

// File: tb/tb_branch_selector_cfg.sv
// Scoreboard bench: stimulus pushes expected merge sets, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_branch_selector_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A (16/16, CNT_W=16) and DUT B (16/16, CNT_W=3) share all inputs
    logic        rst, in_valid, cfg_we, cfg_commit, cnt_clr;
    logic [15:0] merge_set_in;
    logic [3:0]  cfg_addr;
    logic [4:0]  cfg_data;
    logic        out_valid_a, out_valid_b, conf_a, conf_b;
    logic [15:0] out_a, out_b, cnt_a;
    logic [2:0]  cnt_b;

    // DUT C (N_IN=8, N_OUT=5)
    logic        rst_c, in_valid_c, cfg_we_c, cfg_commit_c, cnt_clr_c;
    logic [7:0]  msi_c;
    logic [2:0]  addr_c;
    logic [3:0]  data_c;
    logic        out_valid_c, conf_c;
    logic [4:0]  out_c;
    logic [15:0] cnt_c;

    branch_selector_cfg #(.N_IN(16), .N_OUT(16), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .merge_set_in(merge_set_in),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
        .cnt_clr(cnt_clr), .out_valid(out_valid_a), .merge_set_out(out_a),
        .cfg_conflict(conf_a), .collision_cnt(cnt_a));

    branch_selector_cfg #(.N_IN(16), .N_OUT(16), .CNT_W(3)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .merge_set_in(merge_set_in),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
        .cnt_clr(cnt_clr), .out_valid(out_valid_b), .merge_set_out(out_b),
        .cfg_conflict(conf_b), .collision_cnt(cnt_b));

    branch_selector_cfg #(.N_IN(8), .N_OUT(5), .CNT_W(16)) u_c (
        .clk(clk), .rst(rst_c), .in_valid(in_valid_c), .merge_set_in(msi_c),
        .cfg_we(cfg_we_c), .cfg_addr(addr_c), .cfg_data(data_c), .cfg_commit(cfg_commit_c),
        .cnt_clr(cnt_clr_c), .out_valid(out_valid_c), .merge_set_out(out_c),
        .cfg_conflict(conf_c), .collision_cnt(cnt_c));

    int          n_vec = 0;
    int          n_bad = 0;
    logic        mon_en = 1'b0;
    logic [15:0] exp_q[$];
    logic [4:0]  exp_c_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("valid_b_eq_a", 32'(out_valid_b), 32'(out_valid_a));
            if (out_valid_a) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid_a", 32'(out_valid_a), 32'd0);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    check("out_a", 32'(out_a), 32'(e));
                    check("out_b", 32'(out_b), 32'(e));
                end
            end else begin
                check("idle_out_a", 32'(out_a), 32'd0);
            end
            if (out_valid_c) begin
                if (exp_c_q.size() == 0) begin
                    check("unexpected_valid_c", 32'(out_valid_c), 32'd0);
                end else begin
                    logic [4:0] ec;
                    ec = exp_c_q.pop_front();
                    check("out_c", 32'(out_c), 32'(ec));
                end
            end else begin
                check("idle_out_c", 32'(out_c), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic v, input logic [15:0] d, input logic [15:0] e);
        in_valid     = v;
        merge_set_in = d;
        if (v && !rst) exp_q.push_back(e);
        tick();
        in_valid = 1'b0; merge_set_in = '0; cfg_we = 1'b0; cfg_commit = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [4:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        cyc(1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic cyc_c(input logic v, input logic [7:0] d, input logic [4:0] e);
        in_valid_c = v;
        msi_c      = d;
        if (v && !rst_c) exp_c_q.push_back(e);
        tick();
        in_valid_c = 1'b0; msi_c = '0; cfg_we_c = 1'b0; cfg_commit_c = 1'b0; cnt_clr_c = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0; cnt_clr = 1'b0;
        merge_set_in = '0; cfg_addr = '0; cfg_data = '0;
        rst_c = 1'b1; in_valid_c = 1'b0; cfg_we_c = 1'b0; cfg_commit_c = 1'b0; cnt_clr_c = 1'b0;
        msi_c = '0; addr_c = '0; data_c = '0;
        tick();
        tick();
        rst = 1'b0; rst_c = 1'b0;
        mon_en = 1'b1;
        check("reset_valid_a", 32'(out_valid_a), 32'd0);
        check("reset_conf_a", 32'(conf_a), 32'd0);
        check("reset_cnt_a", 32'(cnt_a), 32'd0);
        check("reset_conf_c", 32'(conf_c), 32'd1);

        // Identity map
        cyc(1'b1, 16'h8001, 16'h8001);
        check("ident_conf_a", 32'(conf_a), 32'd0);
        check("ident_cnt_a", 32'(cnt_a), 32'd0);

        // Shadow all -> 3, not yet committed
        for (int i = 0; i < 16; i++) wr(4'(i), 5'b1_0011);
        cyc(1'b1, 16'h0001, 16'h0001);
        cfg_commit = 1'b1;
        cyc(1'b1, 16'h0001, 16'h0001);
        cyc(1'b1, 16'h0001, 16'h0008);
        check("conf_after_commit", 32'(conf_a), 32'd1);

        // Collisions, clear priority, saturation
        for (int i = 0; i < 5; i++) cyc(1'b1, 16'h0003, 16'h0008);
        check("cnt_a_5", 32'(cnt_a), 32'd5);
        check("cnt_b_5", 32'(cnt_b), 32'd5);
        cnt_clr = 1'b1;
        cyc(1'b1, 16'h0003, 16'h0008);
        check("cnt_a_clr", 32'(cnt_a), 32'd0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 16'h0003, 16'h0008);
        check("cnt_a_10", 32'(cnt_a), 32'd10);
        check("cnt_b_sat", 32'(cnt_b), 32'd7);
        cnt_clr = 1'b1;
        cyc(1'b0, 16'h0000, 16'h0000);
        check("cnt_b_clr", 32'(cnt_b), 32'd0);

        // Disable input 4, then an idle cycle with all bits set
        wr(4'd4, 5'b0_0011);
        cfg_commit = 1'b1;
        cyc(1'b0, 16'h0000, 16'h0000);
        cyc(1'b1, 16'h0010, 16'h0000);
        cyc(1'b0, 16'hFFFF, 16'h0000);
        check("idle_no_count", 32'(cnt_a), 32'd0);

        // Commit and write in the same cycle
        wr(4'd5, 5'b1_1001);
        cfg_commit = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd2; cfg_data = 5'b1_0111;
        cyc(1'b1, 16'h0020, 16'h0008);
        cyc(1'b1, 16'h0024, 16'h0208);
        cfg_commit = 1'b1;
        cyc(1'b0, 16'h0000, 16'h0000);
        cyc(1'b1, 16'h0004, 16'h0080);
        check("conf_still_set", 32'(conf_a), 32'd1);

        // Reset mid-stream with commit and write pending
        cyc(1'b1, 16'h0003, 16'h0008);
        check("cnt_a_pre_rst", 32'(cnt_a), 32'd1);
        rst = 1'b1; cfg_commit = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 5'b1_1111;
        cyc(1'b1, 16'h00FF, 16'h0000);
        rst = 1'b0;
        check("rst_valid", 32'(out_valid_a), 32'd0);
        check("rst_cnt_a", 32'(cnt_a), 32'd0);
        check("rst_conf_a", 32'(conf_a), 32'd0);
        cyc(1'b1, 16'h8001, 16'h8001);
        cfg_commit = 1'b1;
        cyc(1'b1, 16'h0001, 16'h0001);
        cyc(1'b1, 16'h0001, 16'h0001);
        check("rst_conf_recomputed", 32'(conf_a), 32'd0);

        // N_IN=8, N_OUT=5: wrapped identity, out-of-range drop
        cyc_c(1'b1, 8'h21, 5'h01);
        check("c_cnt_1", 32'(cnt_c), 32'd1);
        cyc_c(1'b1, 8'h10, 5'h10);
        cfg_we_c = 1'b1; addr_c = 3'd3; data_c = 4'b1110;
        cyc_c(1'b0, 8'h00, 5'h00);
        cfg_commit_c = 1'b1;
        cyc_c(1'b0, 8'h00, 5'h00);
        cyc_c(1'b1, 8'h08, 5'h00);
        cyc_c(1'b1, 8'h0F, 5'h07);
        check("c_conf", 32'(conf_c), 32'd1);
        check("c_cnt_final", 32'(cnt_c), 32'd1);

        tick();
        tick();
        check("q_a_drained", 32'(exp_q.size()), 32'd0);
        check("q_c_drained", 32'(exp_c_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
